// File: rtl/perf_counter_pkg.sv
// Shared definitions for the performance counter bank.
//   idx_width()  - read-index width for a given channel count, never below 1
//   ovf_mode_e   - behaviour of a counter incremented at its maximum value
//   Prio*        - per-edge priority of the live-counter update sources
package perf_counter_pkg;

    typedef enum logic {
        OvfWrap     = 1'b0,
        OvfSaturate = 1'b1
    } ovf_mode_e;

    // Higher value wins on the same clock edge.
    localparam int unsigned PrioClear     = 2;
    localparam int unsigned PrioRestart   = 1;
    localparam int unsigned PrioIncrement = 0;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_channel.sv
// One live event counter with a sticky overflow flag.
//   clk, rst_n - clock, asynchronous active-low reset
//   inc        - count one event this cycle (already gated by the global enable)
//   clear      - zero counter and flag, dropping this cycle's event
//   restart    - snapshot restart: counter reloads with this cycle's event, flag clears
//   cnt, ovf   - live count and sticky overflow flag
module perf_counter_channel
    import perf_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    input  logic             restart,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf
);

    localparam ovf_mode_e Mode = SATURATE ? OvfSaturate : OvfWrap;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (restart) begin
            // The event arriving on the snapshot edge belongs to the new interval.
            cnt_d = {{(WIDTH-1){1'b0}}, inc};
            ovf_d = 1'b0;
        end else if (inc) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
                if (Mode == OvfWrap) begin
                    cnt_d = '0;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Multi-channel event counter bank with atomic snapshot and indexed shadow read.
//   clk, rst_n         - clock, asynchronous active-low reset
//   enable_in          - global count enable (clear/snapshot/read unaffected)
//   clear_in           - synchronous clear of live counters and overflow flags
//   inc_in             - per-channel event strobes
//   snapshot_in        - copy all live counters/flags into shadow registers
//   snapshot_done_out  - pulses the cycle after each capture edge
//   rd_valid_in        - read request for shadow channel rd_index_in
//   rd_valid_out       - read response, one cycle after the request
//   rd_data_out        - shadow count (0 for out-of-range index), held between reads
//   rd_overflow_out    - shadow overflow flag (0 for out-of-range index)
//   overflow_out       - live sticky overflow flags
module perf_counter_bank
    import perf_counter_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS      = 4,
    parameter int unsigned WIDTH             = 32,
    parameter int unsigned SATURATE          = 0,
    parameter int unsigned CLEAR_ON_SNAPSHOT = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable_in,
    input  logic                                 clear_in,
    input  logic [NUM_CHANNELS-1:0]              inc_in,
    input  logic                                 snapshot_in,
    output logic                                 snapshot_done_out,
    input  logic                                 rd_valid_in,
    input  logic [idx_width(NUM_CHANNELS)-1:0]   rd_index_in,
    output logic                                 rd_valid_out,
    output logic [WIDTH-1:0]                     rd_data_out,
    output logic                                 rd_overflow_out,
    output logic [NUM_CHANNELS-1:0]              overflow_out
);

    localparam int unsigned IDX_W = idx_width(NUM_CHANNELS);

    logic [NUM_CHANNELS-1:0][WIDTH-1:0] cnt;
    logic [NUM_CHANNELS-1:0]            ovf;
    logic [NUM_CHANNELS-1:0][WIDTH-1:0] shadow_cnt_q;
    logic [NUM_CHANNELS-1:0]            shadow_ovf_q;
    logic                               restart;

    logic                               snapshot_done_q;
    logic                               rd_valid_q;
    logic [WIDTH-1:0]                   rd_data_q, rd_data_mux;
    logic                               rd_ovf_q, rd_ovf_mux;

    assign restart = (CLEAR_ON_SNAPSHOT != 0) && snapshot_in;

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        perf_counter_channel #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE != 0)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (enable_in & inc_in[gi]),
            .clear   (clear_in),
            .restart (restart),
            .cnt     (cnt[gi]),
            .ovf     (ovf[gi])
        );
    end

    // Shadows take pre-edge live values, so a simultaneous clear still captures
    // the old counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_cnt_q    <= '0;
            shadow_ovf_q    <= '0;
            snapshot_done_q <= 1'b0;
        end else begin
            snapshot_done_q <= snapshot_in;
            if (snapshot_in) begin
                shadow_cnt_q <= cnt;
                shadow_ovf_q <= ovf;
            end
        end
    end

    // Out-of-range indices match no channel and fall through to zero.
    always_comb begin
        rd_data_mux = '0;
        rd_ovf_mux  = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (rd_index_in == IDX_W'(i)) begin
                rd_data_mux = shadow_cnt_q[i];
                rd_ovf_mux  = shadow_ovf_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_in;
            if (rd_valid_in) begin
                rd_data_q <= rd_data_mux;
                rd_ovf_q  <= rd_ovf_mux;
            end
        end
    end

    assign snapshot_done_out = snapshot_done_q;
    assign rd_valid_out      = rd_valid_q;
    assign rd_data_out       = rd_data_q;
    assign rd_overflow_out   = rd_ovf_q;
    assign overflow_out      = ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;

    // Four banks share stimulus; read requests are steered per bank.
    //   0: N=4 W=8 wrap      1: N=4 W=4 wrap
    //   2: N=4 W=4 saturate  3: N=3 W=8 clear-on-snapshot
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable_in = 1'b0;
    logic       clear_in = 1'b0;
    logic [3:0] inc_in = '0;
    logic       snapshot_in = 1'b0;
    logic [3:0] rdv_in = '0;
    logic [1:0] rd_index_in = '0;

    logic [3:0] done_w;
    logic [3:0] rdv_w;
    logic [3:0] rdo_w;
    logic [7:0] rdd_w [4];
    logic [3:0] ovf_w [4];

    logic [7:0] d0_data, d3_data;
    logic [3:0] d1_data, d2_data;
    logic [3:0] d0_ovf, d1_ovf, d2_ovf;
    logic [2:0] d3_ovf;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CHANNELS(4), .WIDTH(8), .SATURATE(0), .CLEAR_ON_SNAPSHOT(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .clear_in(clear_in), .inc_in(inc_in),
        .snapshot_in(snapshot_in), .snapshot_done_out(done_w[0]), .rd_valid_in(rdv_in[0]),
        .rd_index_in(rd_index_in), .rd_valid_out(rdv_w[0]), .rd_data_out(d0_data),
        .rd_overflow_out(rdo_w[0]), .overflow_out(d0_ovf)
    );
    perf_counter_bank #(.NUM_CHANNELS(4), .WIDTH(4), .SATURATE(0), .CLEAR_ON_SNAPSHOT(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .clear_in(clear_in), .inc_in(inc_in),
        .snapshot_in(snapshot_in), .snapshot_done_out(done_w[1]), .rd_valid_in(rdv_in[1]),
        .rd_index_in(rd_index_in), .rd_valid_out(rdv_w[1]), .rd_data_out(d1_data),
        .rd_overflow_out(rdo_w[1]), .overflow_out(d1_ovf)
    );
    perf_counter_bank #(.NUM_CHANNELS(4), .WIDTH(4), .SATURATE(1), .CLEAR_ON_SNAPSHOT(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .clear_in(clear_in), .inc_in(inc_in),
        .snapshot_in(snapshot_in), .snapshot_done_out(done_w[2]), .rd_valid_in(rdv_in[2]),
        .rd_index_in(rd_index_in), .rd_valid_out(rdv_w[2]), .rd_data_out(d2_data),
        .rd_overflow_out(rdo_w[2]), .overflow_out(d2_ovf)
    );
    perf_counter_bank #(.NUM_CHANNELS(3), .WIDTH(8), .SATURATE(0), .CLEAR_ON_SNAPSHOT(1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .clear_in(clear_in),
        .inc_in(inc_in[2:0]), .snapshot_in(snapshot_in), .snapshot_done_out(done_w[3]),
        .rd_valid_in(rdv_in[3]), .rd_index_in(rd_index_in), .rd_valid_out(rdv_w[3]),
        .rd_data_out(d3_data), .rd_overflow_out(rdo_w[3]), .overflow_out(d3_ovf)
    );

    always_comb begin
        rdd_w[0] = d0_data;
        rdd_w[1] = {4'h0, d1_data};
        rdd_w[2] = {4'h0, d2_data};
        rdd_w[3] = d3_data;
        ovf_w[0] = d0_ovf;
        ovf_w[1] = d1_ovf;
        ovf_w[2] = d2_ovf;
        ovf_w[3] = {1'b0, d3_ovf};
    end

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    exp_t exp_q [4][$];
    int   snap_q [$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response is matched against the head of its bank's queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (exp_q[k].size() > 0 && exp_q[k][0].due <= cyc) begin
                    mon_e = exp_q[k].pop_front();
                    n_tests++;
                    if (!rdv_w[k] || rdd_w[k] !== mon_e.data || rdo_w[k] !== mon_e.ovf) begin
                        n_fail++;
                        $display("FAIL read bank%0d cyc%0d: got v=%b d=%0d o=%b, want v=1 d=%0d o=%b",
                                 k, cyc, rdv_w[k], rdd_w[k], rdo_w[k], mon_e.data, mon_e.ovf);
                    end
                end else if (rdv_w[k] !== 1'b0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_read bank%0d cyc%0d: got v=%b, want v=0",
                             k, cyc, rdv_w[k]);
                end
            end
            if (snap_q.size() > 0 && snap_q[0] <= cyc) begin
                void'(snap_q.pop_front());
                n_tests++;
                if (done_w !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL snapshot_done cyc%0d: got %b, want 1111", cyc, done_w);
                end
            end else if (done_w !== 4'b0000) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_snapshot_done cyc%0d: got %b, want 0000", cyc, done_w);
            end
        end
    end

    task automatic drive(input logic en, input logic clr, input logic [3:0] inc,
                         input logic snap, input int rk, input logic [1:0] idx);
        enable_in   = en;
        clear_in    = clr;
        inc_in      = inc;
        snapshot_in = snap;
        rd_index_in = idx;
        rdv_in      = '0;
        if (rk >= 0) rdv_in[rk] = 1'b1;
        if (snap) snap_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        enable_in   = 1'b0;
        clear_in    = 1'b0;
        inc_in      = '0;
        snapshot_in = 1'b0;
        rdv_in      = '0;
    endtask

    task automatic expect_rd(input int k, input logic [7:0] d, input logic o);
        exp_t e;
        e.due  = cyc + 1;
        e.data = d;
        e.ovf  = o;
        exp_q[k].push_back(e);
    endtask

    task automatic rd(input int k, input logic [1:0] idx, input logic [7:0] d, input logic o);
        expect_rd(k, d, o);
        drive(1'b0, 1'b0, 4'h0, 1'b0, k, idx);
    endtask

    task automatic count(input int n, input logic [3:0] inc);
        repeat (n) drive(1'b1, 1'b0, inc, 1'b0, -1, 2'd0);
    endtask

    task automatic snap();
        drive(1'b0, 1'b0, 4'h0, 1'b1, -1, 2'd0);
    endtask

    task automatic clr();
        drive(1'b0, 1'b1, 4'h0, 1'b0, -1, 2'd0);
    endtask

    task automatic check_ovf(input string name, input int k, input logic [3:0] want);
        n_tests++;
        if (ovf_w[k] !== want) begin
            n_fail++;
            $display("FAIL %s: overflow_out got %b, want %b", name, ovf_w[k], want);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (rdv_w[k] !== 1'b0 || rdd_w[k] !== 8'd0 || rdo_w[k] !== 1'b0 ||
                done_w[k] !== 1'b0 || ovf_w[k] !== 4'd0) begin
                n_fail++;
                $display("FAIL %s bank%0d: got v=%b d=%0d o=%b done=%b ovf=%b, want all 0",
                         name, k, rdv_w[k], rdd_w[k], rdo_w[k], done_w[k], ovf_w[k]);
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset_state");
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(0, 2'd0, 8'd0, 1'b0);                 // shadow starts at 0

        // Basic count, snapshot, read; enable low freezes counting.
        count(10, 4'b0001);
        snap();
        rd(0, 2'd0, 8'd10, 1'b0);
        rd(0, 2'd1, 8'd0, 1'b0);
        rd(3, 2'd0, 8'd10, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 4'b0001, 1'b0, -1, 2'd0);
        snap();
        rd(0, 2'd0, 8'd10, 1'b0);

        // Wrap vs saturate at WIDTH=4.
        clr();
        count(17, 4'b0100);
        check_ovf("wrap_ovf", 1, 4'b0100);
        check_ovf("sat_ovf", 2, 4'b0100);
        check_ovf("w8_no_ovf", 0, 4'b0000);
        snap();
        rd(1, 2'd2, 8'd1, 1'b1);
        rd(2, 2'd2, 8'd15, 1'b1);
        rd(0, 2'd2, 8'd17, 1'b0);
        count(3, 4'b0100);
        snap();
        rd(2, 2'd2, 8'd15, 1'b1);
        rd(1, 2'd2, 8'd4, 1'b1);
        clr();
        check_ovf("clear_ovf", 1, 4'b0000);
        snap();
        rd(1, 2'd2, 8'd0, 1'b0);

        // Clear-on-snapshot restart and clear+snapshot on one edge.
        clr();
        count(5, 4'b0001);
        drive(1'b1, 1'b0, 4'b0001, 1'b1, -1, 2'd0);
        rd(3, 2'd0, 8'd5, 1'b0);
        rd(0, 2'd0, 8'd5, 1'b0);
        snap();
        rd(3, 2'd0, 8'd1, 1'b0);
        rd(0, 2'd0, 8'd6, 1'b0);
        count(2, 4'b0001);
        drive(1'b1, 1'b1, 4'b0001, 1'b1, -1, 2'd0);
        rd(3, 2'd0, 8'd2, 1'b0);
        rd(0, 2'd0, 8'd8, 1'b0);
        snap();
        rd(3, 2'd0, 8'd0, 1'b0);
        rd(0, 2'd0, 8'd0, 1'b0);

        // Read on the snapshot edge returns the old shadow; out-of-range index.
        clr();
        count(3, 4'b0010);
        snap();
        count(2, 4'b0010);
        expect_rd(0, 8'd3, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 0, 2'd1);
        rd(0, 2'd1, 8'd5, 1'b0);
        rd(3, 2'd3, 8'd0, 1'b0);
        rd(0, 2'd3, 8'd0, 1'b0);

        // Asynchronous reset between edges with outputs active.
        count(15, 4'b1111);
        expect_rd(0, 8'd5, 1'b0);
        drive(1'b1, 1'b0, 4'b1111, 1'b1, 0, 2'd1);
        check_ovf("pre_reset_ovf", 1, 4'b1111);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        count(2, 4'b0001);
        snap();
        rd(0, 2'd0, 8'd2, 1'b0);
        rd(1, 2'd0, 8'd2, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() +
            snap_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending responses, want 0",
                     exp_q[0].size() + exp_q[1].size() + exp_q[2].size() +
                     exp_q[3].size() + snap_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
